// File: rtl/intel_hex_loader.sv
// intel_hex_loader: byte-serial Intel HEX parser emitting one {addr,data} write strobe per data byte
module intel_hex_loader (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_addr,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_idle,
  output logic [2:0]  o_error_code,
  output logic        o_parse_complete
);
  localparam logic [2:0] S_WAIT = 3'd0, S_LEN = 3'd1, S_ADDR = 3'd2,
                         S_TYPE = 3'd3, S_DATA = 3'd4, S_CSUM = 3'd5;
  logic [2:0]  state;
  logic [2:0]  typ;
  logic [3:0]  hi;
  logic        lo;
  logic [7:0]  len, bcnt, csum;
  logic [15:0] rec_addr;
  logic        is_hex, ws;
  logic [3:0]  nib;
  logic [7:0]  byte_v, csum_n;
  always_comb begin
    is_hex = (i_data >= "0" && i_data <= "9") || (i_data >= "A" && i_data <= "F") ||
             (i_data >= "a" && i_data <= "f");
    ws     = i_data == 8'h0D || i_data == 8'h0A || i_data == 8'h20 || i_data == 8'h09;
    nib    = (i_data <= "9") ? i_data[3:0] : i_data[3:0] + 4'd9;
    byte_v = {hi, nib};
    csum_n = csum + byte_v;
  end
  assign o_idle = (state == S_WAIT);
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_WAIT;
      typ              <= '0;
      hi               <= '0;
      lo               <= 1'b0;
      len              <= '0;
      bcnt             <= '0;
      csum             <= '0;
      rec_addr         <= '0;
      o_addr           <= '0;
      o_data           <= '0;
      o_data_valid     <= 1'b0;
      o_error_code     <= '0;
      o_parse_complete <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      if (i_en) begin
        if (state == S_WAIT) begin
          if (i_data == ":") begin
            o_error_code     <= '0;
            o_parse_complete <= 1'b0;
            csum             <= '0;
            lo               <= 1'b0;
            state            <= S_LEN;
          end else if (!ws) o_error_code <= 3'd1;
        end else if (i_data == ":") begin
          // a stray ':' is flagged but still opens a fresh record
          o_error_code <= 3'd4;
          csum         <= '0;
          lo           <= 1'b0;
          state        <= S_LEN;
        end else if (!is_hex) begin
          o_error_code <= 3'd4;
          state        <= S_WAIT;
        end else if (!lo) begin
          hi <= nib;
          lo <= 1'b1;
        end else begin
          lo   <= 1'b0;
          csum <= csum_n;
          case (state)
            S_LEN: begin
              len   <= byte_v;
              bcnt  <= '0;
              state <= S_ADDR;
            end
            S_ADDR: begin
              if (bcnt == 8'd0) begin
                rec_addr[15:8] <= byte_v;
                bcnt           <= 8'd1;
              end else begin
                rec_addr[7:0] <= byte_v;
                state         <= S_TYPE;
              end
            end
            S_TYPE: begin
              bcnt <= '0;
              if (byte_v > 8'd5) begin
                o_error_code <= 3'd3;
                state        <= S_WAIT;
              end else begin
                typ   <= byte_v[2:0];
                state <= (len == 8'd0) ? S_CSUM : S_DATA;
              end
            end
            S_DATA: begin
              if (typ == 3'd0) begin
                o_data       <= byte_v;
                o_addr       <= rec_addr + {8'd0, bcnt};
                o_data_valid <= 1'b1;
              end
              bcnt  <= bcnt + 8'd1;
              state <= (bcnt + 8'd1 == len) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
              state <= S_WAIT;
              if (csum_n != 8'd0) o_error_code <= 3'd2;
              else if (typ == 3'd1) o_parse_complete <= 1'b1;
            end
            default: state <= S_WAIT;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_intel_hex_loader.sv
// tb_intel_hex_loader: scoreboard bench for the Intel HEX loader
module tb_intel_hex_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  logic        o_data_valid, o_idle, o_parse_complete;
  logic [2:0]  o_error_code;
  int          checks = 0, errors = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  intel_hex_loader dut (
    .i_clk(clk), .rst_n(rst_n), .i_en(en), .i_data(data),
    .o_addr(o_addr), .o_data(o_data), .o_data_valid(o_data_valid),
    .o_idle(o_idle), .o_error_code(o_error_code), .o_parse_complete(o_parse_complete)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    en   = 1'b1;
    data = c;
    @(negedge clk);
    en   = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    repeat (2) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (o_data_valid) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", {8'd0, o_addr, o_data}, 32'hFFFFFFFF);
      else chk("strobe", {8'd0, o_addr, o_data}, {8'd0, exp_q.pop_front()});
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_idle", o_idle, 1);
    chk("rst_err", o_error_code, 0);
    chk("rst_pc", o_parse_complete, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_valid", o_data_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push(16'h0030, 8'h02); push(16'h0031, 8'h33); push(16'h0032, 8'h7A);
    send_str(":0300300002337A1E\r\n");
    chk("t1_err", o_error_code, 0);
    chk("t1_idle", o_idle, 1);
    chk("t1_pending", exp_q.size(), 0);

    send_str(":");
    chk("t2_idle_in_rec", o_idle, 0);
    send_str("00000001FF");
    chk("t2_pc", o_parse_complete, 1);
    chk("t2_err", o_error_code, 0);
    send_str(":");
    chk("t2_pc_cleared", o_parse_complete, 0);
    send_str("00000001FF");
    chk("t2_pc_again", o_parse_complete, 1);

    push(16'h0000, 8'h41);
    send_str(":0100000041BF");
    chk("t3_err", o_error_code, 2);
    chk("t3_idle", o_idle, 1);
    chk("t3_hold", {o_addr, o_data}, {16'h0000, 8'h41});
    chk("t3_pending", exp_q.size(), 0);

    push(16'hFFFF, 8'hAA); push(16'h0000, 8'hBB);
    send_str(":02FFFF00AABB9B\n");
    chk("t4_err", o_error_code, 0);
    chk("t4_pending", exp_q.size(), 0);
    push(16'hFFFF, 8'hAA); push(16'h0000, 8'hBB);
    send_str(":02ffff00aabb9b\r\n");
    chk("t4_lc_err", o_error_code, 0);
    chk("t4_lc_pending", exp_q.size(), 0);

    send_str(":0100000G");
    chk("t5_nonhex", o_error_code, 4);
    chk("t5_nonhex_idle", o_idle, 1);
    send_str("X");
    chk("t5_outside", o_error_code, 1);
    send_str(":00000009");
    chk("t5_type", o_error_code, 3);
    chk("t5_type_idle", o_idle, 1);
    send_str(":0100:");
    chk("t5_colon_mid", o_error_code, 4);
    send_str("00000001FF");
    chk("t5_recover_pc", o_parse_complete, 1);

    push(16'h1234, 8'h5A);
    send_str(":01123400");
    chk("t6_mid_idle", o_idle, 0);
    send_str("5A");
    chk("t6_addr_set", o_addr, 16'h1234);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_addr", o_addr, 0);
    chk("t6_rst_data", o_data, 0);
    chk("t6_rst_idle", o_idle, 1);
    chk("t6_rst_err", o_error_code, 0);
    chk("t6_rst_pc", o_parse_complete, 0);
    rst_n = 1'b1;
    @(negedge clk);
    push(16'h0030, 8'h02); push(16'h0031, 8'h33); push(16'h0032, 8'h7A);
    send_str(":0300300002337A1E\r\n");
    chk("t6_err", o_error_code, 0);
    chk("t6_idle", o_idle, 1);
    chk("t6_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
